rr_decoder_arbiter: RTL
=======================

Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 one-hot decoder.
- Drives the decoder's address0/address1/enable inputs, so the decoder's one-hot outputs become registered grant lines.
- Holds a grant until the owner releases it, inserts a one-cycle gap between grants, and rotates priority for fairness.

Parameters:
- TIMEOUT_CYCLES, 8: maximum grant length in cycles before a forced release; used only with RR_ARB_TIMEOUT_EN; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the grant-length counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] requests grant i.
- done  input  1  single-cycle release pulse from the current owner.
- address0  output  1  grant index bit 0 (registered); goes to decoder address0.
- address1  output  1  grant index bit 1 (registered); goes to decoder address1.
- enable  output  1  grant valid (registered); goes to decoder enable.
- busy  output  1  high while in GRANT state.
- timeout_flag  output  1  one-cycle pulse on forced release; constant 0 without RR_ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; the ports are named clk and reset.
  - Reset dominates all other inputs.
  - On the first edge with reset=1: address0=0, address1=0, enable=0, busy=0, timeout_flag=0, ptr=0, cnt=0, state=IDLE.
  - Reset asserted mid-grant drops enable on that edge. No release bookkeeping is done; ptr returns to 0.
- Internal state:
  - ptr[1:0]: highest-priority index.
  - cur[1:0]: current owner.
  - cnt[CNT_W-1:0]: grant-length counter.
  - Two-state FSM: IDLE, GRANT.
- IDLE:
  - enable=0, busy=0.
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that edge: cur=i, {address1,address0}=i, enable=1, busy=1, cnt=1, go to GRANT.
  - Latency: req sampled high at edge k gives enable=1 after edge k.
- GRANT:
  - enable=1; address bits hold cur and are stable for the whole grant.
  - Release condition: done=1, or req[cur]=0, or (with the macro) timeout.
  - Simultaneous done and req drop count as a single release.
  - On release: enable=0, busy=0, ptr=cur+1 (mod 4, wraps 3 to 0), go to IDLE.
  - The address bits keep their last value after release; only enable deasserts.
  - Requests from other channels are ignored during GRANT.
- Gap cycle:
  - After a release, at least one IDLE cycle with enable=0 always follows before the next grant.
  - This guarantees the decoder outputs return to all-zero between owners despite gate delays.
- Other rules:
  - done while in IDLE is ignored.
  - cnt saturates at 2^CNT_W-1 and never wraps.
- Fairness: a continuously requesting channel waits at most 3 grants plus their gap cycles.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if cnt==TIMEOUT_CYCLES and no other release condition holds, force the release (same effects as a normal release).
  - On that edge timeout_flag=1, for one cycle.
  - cnt increments each GRANT cycle without a release.
- Undefined:
  - No forced release; a grant lasts until done or req drop.
  - timeout_flag tied 0.
  - cnt may be optimised away.

Test Plan:
- Reset priority: reset 2 cycles, then req=4'b1111 → enable=1 one edge later with {a1,a0}=0. Pulse done → enable=0 for exactly 1 cycle, then grant index 1.
- Rotation and wrap: req=4'b1111 held, done pulsed every 3rd grant cycle → grant order 0,1,2,3,0. Every grant is separated by exactly one enable=0 cycle.
- Request drop and sparse scan: req=4'b1000 from ptr=0 → grant 3. Drop req[3] with done=0 → release next edge and ptr=0. Then req=4'b0101 → grant 0, next grant 2.
- Simultaneous release, stray done, and mid-grant reset:
  - done=1 and req[cur]=0 in the same cycle → single release, ptr advances once.
  - done pulse in IDLE → no effect.
  - reset during GRANT → enable=0 next edge, ptr=0.
- Timeout (macro defined, TIMEOUT_CYCLES=3): req=4'b0010 held, done=0 → enable high 3 cycles, then release with timeout_flag=1 for 1 cycle, one gap cycle, then re-grant 1.
- Timeout disabled (macro undefined): same stimulus → enable stays high for 20+ cycles and timeout_flag stays 0.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter feeding a 2-to-4 one-hot decoder; optional forced release via RR_ARB_TIMEOUT_EN.
// Grant is registered one edge after the request; requesters are held off while a grant is active and for one gap cycle after it.
module rr_decoder_arbiter #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic       address0,
    output logic       address1,
    output logic       enable,
    output logic       busy,
    output logic       timeout_flag
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_cur;
    logic [1:0] r_addr;
    logic       r_en;
    logic       r_busy;
    logic       r_to;

    logic [1:0] w_sel;
    logic       w_any;
    logic       w_tmo;
    logic       w_release;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..2^CNT_W-1");
    end

    // Scan from highest offset down so the entry closest to r_ptr wins.
    always_comb begin
        w_sel = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_sel = r_ptr + 2'(k);
            end
        end
    end

    assign w_any = |req;

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Forced release fires only when no natural release happens on the same edge.
    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES)) & ~done & req[r_cur];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_cnt <= CNT_W'(1);
            end
        end else if (!w_release && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_release = done | ~req[r_cur] | w_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_cur   <= 2'd0;
            r_addr  <= 2'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_to <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cur   <= w_sel;
                        r_addr  <= w_sel;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Address bits deliberately hold after release; only enable drops.
                    if (w_release) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_cur + 2'd1;
                        r_to    <= w_tmo;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign address0     = r_addr[0];
    assign address1     = r_addr[1];
    assign enable       = r_en;
    assign busy         = r_busy;
    assign timeout_flag = r_to;

endmodule
